// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared sizes, FSM encoding and block word extraction for inst_cache
package inst_cache_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int BLOCK_SIZE  = 16;
  localparam int MEM_SIZE    = 1024;
  localparam int LINES       = 8;

  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int INDEX_BITS  = $clog2(LINES);
  localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
  localparam int BLOCK_BITS  = WORD_SIZE * BLOCK_SIZE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  // Word 0 of a block sits in the MSBs, so word i starts (BLOCK_SIZE-1-i) words up from bit 0.
  function automatic logic [WORD_SIZE-1:0] block_word(
    input logic [BLOCK_BITS-1:0]  blk,
    input logic [OFFSET_BITS-1:0] idx
  );
    int lsb;
    lsb = (BLOCK_SIZE - 1 - int'(idx)) * WORD_SIZE;
    block_word = blk[lsb +: WORD_SIZE];
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// rtl/inst_cache_array.sv - valid/tag/data storage with async read, line write and flush-all
module inst_cache_array
  import inst_cache_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [BLOCK_BITS-1:0] o_rd_block,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [BLOCK_BITS-1:0] i_wr_block,
  input  logic                  i_flush
);

  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [BLOCK_BITS-1:0] r_data [LINES];
  logic [LINES-1:0]      w_valid_next;

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_block = r_data[i_rd_index];

  // Flush clears everything first; a refill landing in the same cycle still marks its own line valid.
  always_comb begin
    w_valid_next = i_flush ? '0 : r_valid;
    if (i_wr_en) begin
      w_valid_next[i_wr_index] = 1'b1;
    end
  end

  // Valid bits are the only reset state in the array.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
    end
  end

  // Tag and data are written as a whole line on refill; contents are meaningless until valid.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_block;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped instruction cache with one-beat line refill and hit/miss counters
module inst_cache
  import inst_cache_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic [WORD_SIZE-1:0]  i_cpu_addr,
  output logic                  o_cpu_ready,
  output logic                  o_cpu_valid,
  output logic [WORD_SIZE-1:0]  o_cpu_inst,
  input  logic                  i_flush,
  output logic                  o_mem_req,
  output logic [WORD_SIZE-1:0]  o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic [BLOCK_BITS-1:0] i_mem_block,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count
);

  state_t                 r_state;
  logic                   r_cpu_ready;
  logic                   r_cpu_valid;
  logic [WORD_SIZE-1:0]   r_cpu_inst;
  logic                   r_mem_req;
  logic [WORD_SIZE-1:0]   r_mem_addr;
  logic [OFFSET_BITS-1:0] r_offset;
  logic [31:0]            r_hit_count;
  logic [31:0]            r_miss_count;

  logic [OFFSET_BITS-1:0] w_offset;
  logic [INDEX_BITS-1:0]  w_index;
  logic [TAG_BITS-1:0]    w_tag;
  logic                   w_rd_valid;
  logic [TAG_BITS-1:0]    w_rd_tag;
  logic [BLOCK_BITS-1:0]  w_rd_block;
  logic                   w_hit;
  logic                   w_wr_en;
  logic [INDEX_BITS-1:0]  w_wr_index;
  logic [TAG_BITS-1:0]    w_wr_tag;

  assign w_offset   = i_cpu_addr[OFFSET_BITS-1:0];
  assign w_index    = i_cpu_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_tag      = i_cpu_addr[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS];
  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);

  // The latched block address already carries the index and tag of the line being refilled.
  assign w_wr_en    = (r_state == ST_MISS) && i_mem_ready;
  assign w_wr_index = r_mem_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_wr_tag   = r_mem_addr[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS];

  inst_cache_array u_array (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_block (w_rd_block),
    .i_wr_en    (w_wr_en),
    .i_wr_index (w_wr_index),
    .i_wr_tag   (w_wr_tag),
    .i_wr_block (i_mem_block),
    .i_flush    (i_flush)
  );

  // Fetch FSM: serve hits from the array, refill on miss and bypass the returned word to the CPU.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cpu_ready  <= 1'b1;
      r_cpu_valid  <= 1'b0;
      r_cpu_inst   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_offset     <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_cpu_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cpu_req) begin
            if (w_hit) begin
              r_cpu_inst  <= block_word(w_rd_block, w_offset);
              r_cpu_valid <= 1'b1;
              r_hit_count <= r_hit_count + 32'd1;
            end else begin
              r_mem_addr   <= {i_cpu_addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
              r_offset     <= w_offset;
              r_mem_req    <= 1'b1;
              r_cpu_ready  <= 1'b0;
              r_miss_count <= r_miss_count + 32'd1;
              r_state      <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (i_mem_ready) begin
            r_cpu_inst  <= block_word(i_mem_block, r_offset);
            r_cpu_valid <= 1'b1;
            r_mem_req   <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_ready  = r_cpu_ready;
  assign o_cpu_valid  = r_cpu_valid;
  assign o_cpu_inst   = r_cpu_inst;
  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache against a line-level cache model
module tb_inst_cache;
  import inst_cache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cpu_req;
  logic [31:0]           cpu_addr;
  logic                  cpu_ready;
  logic                  cpu_valid;
  logic [31:0]           cpu_inst;
  logic                  flush;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_ready;
  logic [BLOCK_BITS-1:0] mem_block;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  logic [31:0] mem [MEM_SIZE];
  bit          m_valid [LINES];
  int          m_tag [LINES];
  int          exp_hits;
  int          exp_misses;
  int          n_checks;
  int          n_fail;

  always #5 clk = ~clk;

  inst_cache dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cpu_req    (cpu_req),
    .i_cpu_addr   (cpu_addr),
    .o_cpu_ready  (cpu_ready),
    .o_cpu_valid  (cpu_valid),
    .o_cpu_inst   (cpu_inst),
    .i_flush      (flush),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ready  (mem_ready),
    .i_mem_block  (mem_block),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
  );

  function automatic logic [BLOCK_BITS-1:0] build_block(input logic [31:0] a);
    logic [BLOCK_BITS-1:0] b;
    int base;
    base = int'(a) - int'(a) % BLOCK_SIZE;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      b[(BLOCK_SIZE - i) * 32 - 1 -: 32] = mem[base + i];
    end
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    n_checks++;
    if (hit_count !== 32'(exp_hits)) begin
      n_fail++;
      $display("FAIL %s hit_count: got %0d expected %0d", tag, hit_count, exp_hits);
    end
    n_checks++;
    if (miss_count !== 32'(exp_misses)) begin
      n_fail++;
      $display("FAIL %s miss_count: got %0d expected %0d", tag, miss_count, exp_misses);
    end
  endtask

  // fmode: 0 = no flush, 1 = flush alongside the request, 2 = flush in the cycle after sampling
  task automatic fetch(input logic [31:0] a, input int d, input int fmode);
    int  line;
    int  tg;
    bit  exp_hit;
    line    = (int'(a) / BLOCK_SIZE) % LINES;
    tg      = int'(a) / (BLOCK_SIZE * LINES);
    exp_hit = m_valid[line] && (m_tag[line] == tg);
    n_checks++;
    if (cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_req addr=%h: got %b expected 1", a, cpu_ready);
    end
    cpu_req  = 1'b1;
    cpu_addr = a;
    if (fmode == 1) flush = 1'b1;
    @(posedge clk); @(negedge clk);
    cpu_req = 1'b0;
    flush   = 1'b0;
    if (fmode == 1) model_clear();
    if (exp_hit) exp_hits++; else exp_misses++;
    n_checks++;
    if (cpu_valid !== exp_hit) begin
      n_fail++;
      $display("FAIL hit_flag addr=%h: got valid=%b expected %b", a, cpu_valid, exp_hit);
    end
    if (cpu_valid === 1'b1) begin
      n_checks++;
      if (cpu_inst !== mem[a] || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL hit_data addr=%h: got inst=%h mem_req=%b expected inst=%h mem_req=0", a, cpu_inst, mem_req, mem[a]);
      end
      if (fmode == 2) begin
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        model_clear();
      end
    end else if (mem_req === 1'b1) begin
      n_checks++;
      if (mem_addr !== (a - a % BLOCK_SIZE)) begin
        n_fail++;
        $display("FAIL mem_addr addr=%h: got %h expected %h", a, mem_addr, a - a % BLOCK_SIZE);
      end
      if (fmode == 2) flush = 1'b1;
      for (int k = 1; k < d; k++) begin
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || cpu_valid !== 1'b0 || cpu_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL miss_wait addr=%h cycle %0d: got mem_req=%b valid=%b ready=%b expected 1 0 0", a, k, mem_req, cpu_valid, cpu_ready);
        end
      end
      mem_ready = 1'b1;
      mem_block = build_block(a);
      @(posedge clk); @(negedge clk);
      mem_ready = 1'b0;
      flush     = 1'b0;
      if (fmode == 2) model_clear();
      m_valid[line] = 1'b1;
      m_tag[line]   = tg;
      n_checks++;
      if (cpu_valid !== 1'b1 || cpu_inst !== mem[a] || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL refill addr=%h: got valid=%b inst=%h mem_req=%b expected 1 %h 0", a, cpu_valid, cpu_inst, mem_req, mem[a]);
      end
    end else begin
      n_fail++;
      $display("FAIL no_response addr=%h: got neither cpu_valid nor mem_req", a);
    end
    check_counters("fetch");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_valid !== 1'b0 || cpu_inst !== 32'h0 ||
        mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b inst=%h mem_req=%b mem_addr=%h expected 1 0 0 0 0",
               cpu_ready, cpu_valid, cpu_inst, mem_req, mem_addr);
    end
    check_counters("reset");
  endtask

  task automatic test_cold_miss();
    fetch(32'h24, 3, 0);
  endtask

  task automatic test_hit_after_fill();
    fetch(32'h2F, 2, 0);
    fetch(32'h20, 2, 0);
  endtask

  task automatic test_conflict();
    fetch(32'hA4, 1, 0);
    fetch(32'h24, 2, 0);
  endtask

  task automatic test_back_to_back();
    fetch(32'h20, 2, 0);
    cpu_req  = 1'b1;
    cpu_addr = 32'h20;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      @(posedge clk); @(negedge clk);
      exp_hits++;
      n_checks++;
      if (cpu_valid !== 1'b1 || cpu_ready !== 1'b1 || cpu_inst !== mem[32'h20 + i]) begin
        n_fail++;
        $display("FAIL back_to_back word %0d: got valid=%b ready=%b inst=%h expected 1 1 %h",
                 i, cpu_valid, cpu_ready, cpu_inst, mem[32'h20 + i]);
      end
      if (i < BLOCK_SIZE - 1) cpu_addr = 32'h20 + 32'(i + 1);
      else cpu_req = 1'b0;
    end
    check_counters("back_to_back");
  endtask

  task automatic test_flush();
    fetch(32'h40, 3, 2);
    fetch(32'h40, 1, 0);
    fetch(32'h24, 2, 0);
    fetch(32'h24, 1, 1);
    fetch(32'h24, 2, 0);
  endtask

  task automatic test_reset_mid_miss();
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    model_clear();
    cpu_req  = 1'b1;
    cpu_addr = 32'h24;
    @(posedge clk); @(negedge clk);
    cpu_req = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_miss_start: got mem_req=%b expected 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_mem_req: got %b expected 0", mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    exp_hits   = 0;
    exp_misses = 0;
    mem_ready  = 1'b1;
    mem_block  = build_block(32'h24);
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (cpu_valid !== 1'b0 || mem_req !== 1'b0 || cpu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL late_mem_ready cycle %0d: got valid=%b mem_req=%b ready=%b expected 0 0 1", i, cpu_valid, mem_req, cpu_ready);
      end
      @(posedge clk); @(negedge clk);
    end
    check_counters("reset_mid_miss");
    fetch(32'h24, 2, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int fm;
      a  = 32'($urandom_range(0, MEM_SIZE - 1));
      fm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      fetch(a, int'($urandom_range(1, 4)), fm);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_hits   = 0;
    exp_misses = 0;
    rst_n      = 1'b0;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    flush      = 1'b0;
    mem_ready  = 1'b0;
    mem_block  = '0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
    mem[32'h24] = 32'hDEADBEEF;
    model_clear();
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
